// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH independent up/down counters with per-channel terminal-count
// handling (wrap, saturate, one-shot, auto-reload), terminal pulse and sticky done.
module multi_channel_counter #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         load,
    input  logic [NUM_CH*WIDTH-1:0]   load_value,
    input  logic [NUM_CH-1:0]         tick,
    input  logic [NUM_CH-1:0]         dir,
    input  logic [2*NUM_CH-1:0]       mode,
    input  logic [NUM_CH-1:0]         clear_done,
    output logic [NUM_CH*WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         tc_pulse,
    output logic [NUM_CH-1:0]         done
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_ONESHT = 2'b10;
    localparam logic [1:0] MODE_RELOAD = 2'b11;

    logic [NUM_CH*WIDTH-1:0] count_q,   count_d;
    logic [NUM_CH*WIDTH-1:0] reload_q,  reload_d;
    logic [NUM_CH-1:0]       running_q, running_d;
    logic [NUM_CH-1:0]       tc_q,      tc_d;
    logic [NUM_CH-1:0]       done_q,    done_d;

    function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] cur,
                                                     input logic up);
        return up ? (cur + ONE) : (cur - ONE);
    endfunction

    function automatic logic [WIDTH-1:0] terminal_of(input logic up);
        return up ? ALL_ONES : ZERO;
    endfunction

    // Next-state for every channel; load beats tick, done set beats clear.
    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        running_d = running_q;
        tc_d      = {NUM_CH{1'b0}};
        done_d    = done_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                count_d[i*WIDTH +: WIDTH]  = load_value[i*WIDTH +: WIDTH];
                reload_d[i*WIDTH +: WIDTH] = load_value[i*WIDTH +: WIDTH];
                running_d[i]               = 1'b1;
            end else if (tick[i] && running_q[i]) begin
                if (count_q[i*WIDTH +: WIDTH] != terminal_of(dir[i])) begin
                    count_d[i*WIDTH +: WIDTH] = step_count(count_q[i*WIDTH +: WIDTH], dir[i]);
                end else begin
                    tc_d[i] = 1'b1;
                    case (mode[2*i +: 2])
                        MODE_WRAP:   count_d[i*WIDTH +: WIDTH] = step_count(count_q[i*WIDTH +: WIDTH], dir[i]);
                        MODE_SAT:    count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH];
                        MODE_ONESHT: running_d[i] = 1'b0;
                        MODE_RELOAD: count_d[i*WIDTH +: WIDTH] = reload_q[i*WIDTH +: WIDTH];
                        default:     count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH];
                    endcase
                end
            end else begin
                count_d[i*WIDTH +: WIDTH] = count_q[i*WIDTH +: WIDTH];
            end

            if (tc_d[i]) begin
                done_d[i] = 1'b1;
            end else if (clear_done[i]) begin
                done_d[i] = 1'b0;
            end else begin
                done_d[i] = done_q[i];
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= {(NUM_CH*WIDTH){1'b0}};
            reload_q  <= {(NUM_CH*WIDTH){1'b0}};
            running_q <= {NUM_CH{1'b1}};
            tc_q      <= {NUM_CH{1'b0}};
            done_q    <= {NUM_CH{1'b0}};
        end else begin
            count_q   <= count_d;
            reload_q  <= reload_d;
            running_q <= running_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
        end
    end

    assign count    = count_q;
    assign running  = running_q;
    assign tc_pulse = tc_q;
    assign done     = done_q;

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed bench for multi_channel_counter with WIDTH=4, NUM_CH=2.
module tb_multi_channel_counter;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   load;
    logic [N*W-1:0] load_value;
    logic [N-1:0]   tick;
    logic [N-1:0]   dir;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clear_done;
    logic [N*W-1:0] count;
    logic [N-1:0]   running;
    logic [N-1:0]   tc_pulse;
    logic [N-1:0]   done;

    int checks = 0;
    int errors = 0;

    multi_channel_counter #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_value(load_value),
        .tick(tick), .dir(dir), .mode(mode), .clear_done(clear_done),
        .count(count), .running(running), .tc_pulse(tc_pulse), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ar_cnt [6] = '{4'hE, 4'hF, 4'hD, 4'hE, 4'hF, 4'hD};
    logic       ar_tc  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] os_cnt [5] = '{4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
    logic       os_tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       os_run [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        reset_n = 1'b0; load = 2'b00; load_value = 8'h00; tick = 2'b00;
        dir = 2'b00; mode = 4'b0000; clear_done = 2'b00;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_count", 32'(count), 32'h00);
        chk("reset_running", 32'(running), 32'h3);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_tc", 32'(tc_pulse), 32'h0);

        // ch0 wrap up: 15 ticks to F, 16th wraps with a pulse
        dir = 2'b01; mode = 4'b0000; tick = 2'b01;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("wrap_count", 32'(count[3:0]), 32'(k));
            chk("wrap_no_tc", 32'(tc_pulse[0]), 32'h0);
        end
        step();
        chk("wrap_to_zero", 32'(count[3:0]), 32'h0);
        chk("wrap_tc", 32'(tc_pulse[0]), 32'h1);
        chk("wrap_done", 32'(done[0]), 32'h1);
        tick = 2'b00;
        step();
        chk("wrap_tc_one_cycle", 32'(tc_pulse[0]), 32'h0);
        chk("wrap_done_sticky", 32'(done[0]), 32'h1);

        // ch1 one-shot down from 3
        load = 2'b10; load_value = 8'h30; mode = 4'b1000; dir = 2'b01;
        step();
        chk("os_load", 32'(count[7:4]), 32'h3);
        load = 2'b00; tick = 2'b10;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("os_count", 32'(count[7:4]), 32'(os_cnt[k]));
            chk("os_tc", 32'(tc_pulse[1]), 32'(os_tc[k]));
            chk("os_running", 32'(running[1]), 32'(os_run[k]));
        end
        chk("os_done", 32'(done[1]), 32'h1);
        chk("os_ch0_idle", 32'(count[3:0]), 32'h0);
        tick = 2'b00; load = 2'b10; load_value = 8'h50;
        step();
        chk("os_reload_running", 32'(running[1]), 32'h1);
        chk("os_reload_count", 32'(count[7:4]), 32'h5);
        chk("os_load_keeps_done", 32'(done[1]), 32'h1);

        // ch0 auto-reload from D, ch1 saturate down at 0
        load = 2'b11; load_value = 8'h0D; dir = 2'b01; mode = 4'b0111;
        step();
        chk("ar_load", 32'(count), 32'h0D);
        load = 2'b00; tick = 2'b11;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("ar_count", 32'(count[3:0]), 32'(ar_cnt[k]));
            chk("ar_tc", 32'(tc_pulse[0]), 32'(ar_tc[k]));
            chk("sat_count", 32'(count[7:4]), 32'h0);
            chk("sat_tc", 32'(tc_pulse[1]), 32'h1);
        end

        // load and tick together on ch0
        tick = 2'b01; load = 2'b01; load_value = 8'h07;
        step();
        chk("load_tick_count", 32'(count[3:0]), 32'h7);
        chk("load_tick_no_tc", 32'(tc_pulse[0]), 32'h0);

        load = 2'b00; tick = 2'b00; clear_done = 2'b01;
        step();
        chk("clear_done_alone", 32'(done[0]), 32'h0);
        chk("clear_done_other_ch", 32'(done[1]), 32'h1);

        clear_done = 2'b00; load = 2'b01; load_value = 8'h0F; mode = 4'b0001;
        step();
        chk("sat_load_f", 32'(count[3:0]), 32'hF);
        load = 2'b00; tick = 2'b01; clear_done = 2'b01;
        step();
        chk("set_beats_clear_done", 32'(done[0]), 32'h1);
        chk("set_beats_clear_tc", 32'(tc_pulse[0]), 32'h1);
        chk("set_beats_clear_count", 32'(count[3:0]), 32'hF);

        // asynchronous reset mid-count
        tick = 2'b00; clear_done = 2'b00; load = 2'b01; load_value = 8'h09;
        step();
        chk("pre_reset_count", 32'(count[3:0]), 32'h9);
        load = 2'b00;
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 32'h00);
        chk("async_reset_done", 32'(done), 32'h0);
        chk("async_reset_running", 32'(running), 32'h3);
        #1 reset_n = 1'b1;
        mode = 4'b0000; dir = 2'b01; tick = 2'b01;
        step();
        chk("resume_count", 32'(count[3:0]), 32'h1);
        tick = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_counter.md
Name: multi_channel_counter

Overview:
- Parametrised bank of NUM_CH independent counters. Each channel has its own run-time direction, loadable start value, terminal-count mode (wrap / saturate / one-shot / auto-reload), terminal-count pulse and sticky done flag.
- Used as the common timer/sequencing primitive by control FSMs: bit counters, timeouts, periodic strobes.
- Channels share only clock and reset.

Parameters:
- WIDTH, 8, bits per channel count (>=1).
- NUM_CH, 2, number of channels (>=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load  input  NUM_CH  per-channel load strobe.
- load_value  input  NUM_CH*WIDTH  per-channel load value; channel i at [i*WIDTH +: WIDTH].
- tick  input  NUM_CH  per-channel count enable.
- dir  input  NUM_CH  1 = count up, 0 = count down; sampled on every tick.
- mode  input  2*NUM_CH  per-channel terminal mode; channel i at [2i +: 2]. 00 wrap, 01 saturate, 10 one-shot, 11 auto-reload.
- clear_done  input  NUM_CH  per-channel clear of sticky done.
- count  output  NUM_CH*WIDTH  current count, registered.
- running  output  NUM_CH  channel accepts ticks.
- tc_pulse  output  NUM_CH  registered one-cycle terminal-event pulse.
- done  output  NUM_CH  sticky terminal flag.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-count), per channel:
  - count = 0, reload register = 0, running = 1, tc_pulse = 0, done = 0.
  - Deassertion is synchronous to clk.
- Terminal value T per channel: all-ones when dir=1, zero when dir=0. Evaluated with the dir value present on the same edge.
- Per channel, per edge, priority load > tick:
  - load=1:
    - count <= load_value slice; reload register <= same value; running <= 1.
    - tick ignored; no terminal event; done unchanged.
  - load=0, tick=1, running=1 → accepted tick:
    - If count != T: count <= count+1 (dir=1) or count-1 (dir=0), modulo 2^WIDTH.
    - If count == T, this is a terminal event; action depends on mode:
      - wrap: count <= count±1 (wraps to 0 or all-ones).
      - saturate: count holds at T.
      - one-shot: count holds at T; running <= 0.
      - auto-reload: count <= reload register.
  - tick while running=0: ignored; count holds; no event.
  - tick=0: everything holds.
- tc_pulse:
  - Goes high on the edge that processes a terminal event, for exactly one cycle.
  - Consecutive terminal events give consecutive high cycles (saturate at T with continuous ticks: high every cycle).
- done:
  - Set on the edge processing a terminal event.
  - Cleared by clear_done.
  - Set and clear on the same edge: set wins.
  - Unaffected by load.
- running: only a one-shot terminal event clears it; only load or reset sets it.
- Auto-reload with reload register == T: every accepted tick is a terminal event and count stays T.
- mode and dir may change between ticks. The action uses the values present on the edge.
- Channels are fully independent. Simultaneous events on different channels do not interact.
- No combinational path from any input to any output.
- Latency: every input affects outputs exactly one edge later.

Test Plan:
- WIDTH=4, NUM_CH=2, after reset → count=0x00, running=2'b11, done=0, tc_pulse=0. With ch0 dir=1 mode=wrap, 15 ticks → count0=F, no pulse. 16th tick → count0=0, tc_pulse[0] high one cycle, done[0]=1.
- ch1 load 3, dir=0, mode=one-shot, continuous ticks → count1 sequence 2,1,0, then 0 held; tc_pulse[1] once on the 4th tick; running[1]=0. Further ticks leave count1=0. A load of 5 → running[1]=1, count1=5.
- ch0 load 0xD, dir=1, mode=auto-reload, continuous ticks → count0 sequence E,F,D,E,F,D…; tc_pulse[0] on every third tick. Meanwhile ch1 saturate down at 0 with ticks → tc_pulse[1] every cycle, count1=0.
- Same-edge collisions:
  - load and tick together on ch0 (load_value=7) → count0=7, no tc_pulse.
  - clear_done and terminal event together → done stays 1.
  - clear_done alone → done=0 next cycle.
- Mid-count reset: reset_n low between edges while count0=9 → count0=0, done=0, running=1 immediately (asynchronous). Ticks resume after reset_n high.
